moving_sum: RTL and testbench

Windowed running-sum stage that owns the 87-entry sample FIFO in the timHAF datapath. It accepts a 16-bit signed sample stream, pushes each sample into the FIFO, and pulls the sample that is WIN samples old once the window is primed. It emits y[n] = Σ x[n-k] for k = 0..WIN-1, computed recursively as acc + x_new − x_old. Sits directly upstream of the FIFO (drives its write/read/data pins) and downstream of it (consumes its registered output).

---
 rtl/moving_sum_pkg.sv | 13 +
 rtl/moving_sum_sat.sv | 24 ++
 rtl/moving_sum.sv | 129 ++++++++++++
 tb/tb_moving_sum.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moving_sum_pkg.sv
// Shared defaults and state encoding for the moving_sum windowed running-sum stage.
package moving_sum_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_WIN   = 86;
    localparam int unsigned DEF_ACC_W = DEF_WIDTH + 7;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/moving_sum_sat.sv
// Signed clamp from the full-width accumulator down to the sample width.
module moving_sum_sat
    import moving_sum_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_ACC_W,
    parameter int unsigned OUT_W = DEF_WIDTH
) (
    input  logic signed [IN_W-1:0]  acc_i,
    output logic signed [OUT_W-1:0] sat_o
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    always_comb begin
        sat_o = acc_i[OUT_W-1:0];
        if (acc_i > MAX_V) begin
            sat_o = MAX_V[OUT_W-1:0];
        end else if (acc_i < MIN_V) begin
            sat_o = MIN_V[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/moving_sum.sv
// Windowed running sum over the last WIN samples using an external 87-entry FIFO.
// Define MOVSUM_SAT_EN to narrow sum_out to WIDTH bits with output-only saturation.
module moving_sum
    import moving_sum_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned WIN   = DEF_WIN,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    fifo_wr_en,
    output logic                    fifo_rd_en,
    output logic signed [WIDTH-1:0] fifo_din,
    input  logic signed [WIDTH-1:0] fifo_dout,
    output logic                    out_valid,
`ifdef MOVSUM_SAT_EN
    output logic signed [WIDTH-1:0] sum_out,
`else
    output logic signed [ACC_W-1:0] sum_out,
`endif
    output logic                    primed
);

    localparam int unsigned CNT_W = $clog2(WIN + 1);
    localparam int unsigned EXT_W = ACC_W - WIDTH;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;

    logic signed [WIDTH-1:0] x_d1_q;
    logic                    v_d1_q;
    logic                    pop_d1_q;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] x_ext, old_ext;

    // Window bookkeeping: push only while filling, push and pop together once full.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        fifo_din   = '0;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    fifo_wr_en = 1'b1;
                    fifo_din   = in_data;
                    fill_cnt_d = fill_cnt_q + CNT_W'(1);
                    if (fill_cnt_q == CNT_W'(WIN - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    fifo_wr_en = 1'b1;
                    fifo_rd_en = 1'b1;
                    fifo_din   = in_data;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // Stage 1 aligns the new sample with the FIFO's registered read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_d1_q   <= '0;
            v_d1_q   <= 1'b0;
            pop_d1_q <= 1'b0;
        end else begin
            x_d1_q   <= in_data;
            v_d1_q   <= in_valid;
            pop_d1_q <= fifo_rd_en;
        end
    end

    assign x_ext   = {{EXT_W{x_d1_q[WIDTH-1]}}, x_d1_q};
    assign old_ext = pop_d1_q ? {{EXT_W{fifo_dout[WIDTH-1]}}, fifo_dout} : '0;

    always_comb begin
        acc_d = acc_q;
        if (v_d1_q) begin
            acc_d = acc_q + x_ext - old_ext;
        end
    end

    // Stage 2: recursive update, add the newest sample and retire the oldest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= v_d1_q;
        end
    end

    assign out_valid = out_valid_q;
    assign primed    = (state_q == RUN);

`ifdef MOVSUM_SAT_EN
    moving_sum_sat #(
        .IN_W  (ACC_W),
        .OUT_W (WIDTH)
    ) u_sat (
        .acc_i (acc_q),
        .sat_o (sum_out)
    );
`else
    assign sum_out = acc_q;
`endif

endmodule

// File: tb/tb_moving_sum.sv
// Self-checking bench for moving_sum with a behavioural FIFO and a window-sum reference model.
module tb_moving_sum;

    localparam int WIDTH = 16;
    localparam int WIN   = 86;
    localparam int ACC_W = 23;
`ifdef MOVSUM_SAT_EN
    localparam int OUT_W = WIDTH;
    localparam bit SAT   = 1'b1;
`else
    localparam int OUT_W = ACC_W;
    localparam bit SAT   = 1'b0;
`endif
    localparam int SMAX = 2 ** (WIDTH - 1) - 1;
    localparam int SMIN = -(2 ** (WIDTH - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic signed [WIDTH-1:0] in_data = '0;
    logic fifo_wr_en, fifo_rd_en;
    logic signed [WIDTH-1:0] fifo_din;
    logic signed [WIDTH-1:0] fifo_dout;
    logic out_valid, primed;
    logic signed [OUT_W-1:0] sum_out;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;

    int hist[$];
    int exp_q[$];
    int got_q[$];
    int drv_cyc[$];
    int got_cyc[$];
    int obs_wr[$];
    int obs_rd[$];
    int obs_din[$];
    int exp_rd[$];
    int exp_din[$];
    int fifo_q[$];

    moving_sum dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .fifo_wr_en (fifo_wr_en),
        .fifo_rd_en (fifo_rd_en),
        .fifo_din   (fifo_din),
        .fifo_dout  (fifo_dout),
        .out_valid  (out_valid),
        .sum_out    (sum_out),
        .primed     (primed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-output FIFO: read data appears the cycle after fifo_rd_en.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_q.delete();
            fifo_dout <= '0;
        end else begin
            if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= WIDTH'(fifo_q.pop_front());
            if (fifo_wr_en) fifo_q.push_back(int'(fifo_din));
        end
    end

    always @(negedge clk) begin
        if (rst && out_valid) begin
            got_q.push_back(int'(sum_out));
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sum of the most recent WIN accepted samples, clamped when saturation is built in.
    function automatic int model_sum();
        int s = 0;
        int n = hist.size();
        for (int k = 0; k < WIN && k < n; k++) s += hist[n - 1 - k];
        if (SAT) begin
            if (s > SMAX) s = SMAX;
            else if (s < SMIN) s = SMIN;
        end
        return s;
    endfunction

    task automatic flush_obs();
        exp_q.delete(); got_q.delete(); drv_cyc.delete(); got_cyc.delete();
        obs_wr.delete(); obs_rd.delete(); obs_din.delete(); exp_rd.delete(); exp_din.delete();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int d);
        exp_rd.push_back(hist.size() >= WIN ? 1 : 0);
        exp_din.push_back(d);
        hist.push_back(d);
        exp_q.push_back(model_sum());
        drv_cyc.push_back(cyc);
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        #1;
        obs_wr.push_back(int'(fifo_wr_en));
        obs_rd.push_back(int'(fifo_rd_en));
        obs_din.push_back(int'(fifo_din));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
        flush_obs();
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || sum_out !== '0 || primed !== 1'b0)
            $display("FAIL reset_outputs out_valid=%b sum_out=%0d primed=%b, want 0/0/0", out_valid, sum_out, primed);
        else n_pass++;
        n_checks++;
        if (fifo_wr_en !== 1'b0 || fifo_rd_en !== 1'b0 || fifo_din !== '0)
            $display("FAIL reset_fifo_pins wr=%b rd=%b din=%0d, want 0/0/0", fifo_wr_en, fifo_rd_en, fifo_din);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_ones();
        for (int i = 0; i < WIN; i++) begin
            drive(1);
            n_checks++;
            if (primed !== ((i + 1 >= WIN) ? 1'b1 : 1'b0))
                $display("FAIL fill_primed sample=%0d got=%b want=%b", i + 1, primed, (i + 1 >= WIN));
            else n_pass++;
        end
        idle(4);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL fill_count got=%0d want=%0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] - drv_cyc[i] !== 2)
                $display("FAIL fill_sum idx=%0d got=%0d lat=%0d want=%0d lat=2", i, got_q[i], got_cyc[i] - drv_cyc[i], exp_q[i]);
            else n_pass++;
        end
        for (int i = 0; i < obs_rd.size(); i++) begin
            n_checks++;
            if (obs_wr[i] !== 1 || obs_rd[i] !== exp_rd[i] || obs_din[i] !== exp_din[i])
                $display("FAIL fill_fifo_pins idx=%0d wr=%0d rd=%0d din=%0d want 1/%0d/%0d", i, obs_wr[i], obs_rd[i], obs_din[i], exp_rd[i], exp_din[i]);
            else n_pass++;
        end
        flush_obs();
    endtask

    task automatic test_steady_ones();
        for (int i = 0; i < 20; i++) drive(1);
        idle(4);
        n_checks++;
        if (got_q.size() !== 20) $display("FAIL steady_count got=%0d want=20", got_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_q[i] !== WIN || got_cyc[i] - drv_cyc[i] !== 2)
                $display("FAIL steady_sum idx=%0d got=%0d lat=%0d want=%0d lat=2", i, got_q[i], got_cyc[i] - drv_cyc[i], exp_q[i]);
            else n_pass++;
        end
        for (int i = 0; i < obs_rd.size(); i++) begin
            n_checks++;
            if (obs_wr[i] !== 1 || obs_rd[i] !== 1 || obs_din[i] !== exp_din[i])
                $display("FAIL steady_fifo_pins idx=%0d wr=%0d rd=%0d din=%0d want 1/1/%0d", i, obs_wr[i], obs_rd[i], obs_din[i], exp_din[i]);
            else n_pass++;
        end
        n_checks++;
        if (primed !== 1'b1) $display("FAIL steady_primed got=%b want=1", primed);
        else n_pass++;
        flush_obs();
    endtask

    task automatic test_ramp_gaps();
        do_reset();
        for (int i = 1; i <= 200; i++) begin
            drive(i);
            idle(int'($urandom_range(3)));
        end
        idle(4);
        n_checks++;
        if (got_q.size() !== 200) $display("FAIL ramp_count got=%0d want=200", got_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_cyc[i] - drv_cyc[i] !== 2)
                $display("FAIL ramp_sum idx=%0d got=%0d lat=%0d want=%0d lat=2", i, got_q[i], got_cyc[i] - drv_cyc[i], exp_q[i]);
            else n_pass++;
        end
        for (int i = 0; i < obs_rd.size(); i++) begin
            n_checks++;
            if (obs_wr[i] !== 1 || obs_rd[i] !== exp_rd[i] || obs_din[i] !== exp_din[i])
                $display("FAIL ramp_fifo_pins idx=%0d wr=%0d rd=%0d din=%0d want 1/%0d/%0d", i, obs_wr[i], obs_rd[i], obs_din[i], exp_rd[i], exp_din[i]);
            else n_pass++;
        end
        n_checks++;
        if (got_q.size() != 200 || got_q[199] !== (2 * 200 - WIN + 1) * WIN / 2)
            $display("FAIL ramp_final got=%0d want=%0d", (got_q.size() > 0) ? got_q[got_q.size() - 1] : 0, (2 * 200 - WIN + 1) * WIN / 2);
        else n_pass++;
        flush_obs();
    endtask

    task automatic test_min_neg();
        int want;
        do_reset();
        for (int i = 0; i < WIN; i++) drive(SMIN);
        idle(4);
        want = SAT ? SMIN : WIN * SMIN;
        n_checks++;
        if (got_q.size() !== WIN || got_q[WIN - 1] !== want)
            $display("FAIL minneg_final got=%0d want=%0d", (got_q.size() > 0) ? got_q[got_q.size() - 1] : 0, want);
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL minneg_sum idx=%0d got=%0d want=%0d", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        flush_obs();
    endtask

    task automatic test_sat_peak();
        int peak;
        int want;
        do_reset();
        for (int i = 0; i < WIN; i++) drive(1000);
        for (int i = 0; i < WIN; i++) drive(0);
        idle(4);
        peak = SMIN * WIN;
        foreach (got_q[i]) if (got_q[i] > peak) peak = got_q[i];
        want = SAT ? SMAX : WIN * 1000;
        n_checks++;
        if (peak !== want) $display("FAIL sat_peak got=%0d want=%0d", peak, want);
        else n_pass++;
        n_checks++;
        if (got_q.size() !== 2 * WIN || got_q[2 * WIN - 1] !== 0)
            $display("FAIL sat_final got=%0d want=0 count=%0d", (got_q.size() > 0) ? got_q[got_q.size() - 1] : -1, got_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL sat_sum idx=%0d got=%0d want=%0d", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        flush_obs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 50; i++) drive(int'($urandom_range(65535)) - 32768);
        idle(4);
        n_checks++;
        if (got_q.size() !== 50) $display("FAIL mid_count got=%0d want=50", got_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL mid_sum idx=%0d got=%0d want=%0d", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || sum_out !== '0 || primed !== 1'b0)
            $display("FAIL mid_reset out_valid=%b sum_out=%0d primed=%b, want 0/0/0", out_valid, sum_out, primed);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
        flush_obs();
        @(negedge clk);
        drive(5);
        idle(4);
        n_checks++;
        if (got_q.size() !== 1 || got_q[0] !== 5 || primed !== 1'b0)
            $display("FAIL mid_restart got=%0d count=%0d primed=%b want=5 count=1 primed=0", (got_q.size() > 0) ? got_q[0] : 0, got_q.size(), primed);
        else n_pass++;
        flush_obs();
    endtask

    initial begin
        test_reset();
        test_fill_ones();
        test_steady_ones();
        test_ramp_gaps();
        test_min_neg();
        test_sat_peak();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
